dma_dsc_cache_rd: RTL
=====================

# dma_dsc_cache_rd

Read engine for the DMA descriptor cache. It tracks the cache as a circular buffer against the write pointer published by the descriptor fetch logic, and issues reads to the cache's registered-read port (one-cycle latency). It also absorbs that latency in a two-entry output buffer and presents descriptors to the channel sequencer on a valid/ready interface. It sits between the descriptor cache RAM and the sequencer, and returns its read pointer to the writer for full detection.

## Interface
Parameters:
- WIDTH, 128, descriptor width in bits (equals cache width)
- DEPTH, 128, cache entries; power of two, at least 2
- AW, 7, cache address width, log2(DEPTH)

Ports:
- CLOCK  in  1  single clock for the block; all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- WR_PTR  in  AW+1  writer pointer: MSB is the wrap bit, LSBs are the next cache address to be written
- RD_PTR  out  AW+1  read pointer: count of entries consumed from the cache, with wrap bit
- REN  out  1  cache read enable
- RADDR  out  AW  cache read address, equal to RD_PTR[AW-1:0]
- RDATA  in  WIDTH  cache read data, valid the cycle after REN
- DSC_VALID  out  1  descriptor available
- DSC_READY  in  1  sequencer accepts the descriptor
- DSC_DATA  out  WIDTH  head descriptor
- FLUSH  in  1  discard all unconsumed descriptors
- LEVEL  out  AW+1  WR_PTR − RD_PTR, modulo 2^(AW+1)
- EMPTY  out  1  LEVEL == 0

## Operation
- Cache empty when WR_PTR == RD_PTR. Full when the LSBs are equal and the MSBs differ; the writer performs full detection.
- Internal state:
  - occ: buffer occupancy, 0..2
  - infl: read in flight, 0..1
- REN = !EMPTY && !FLUSH && (occ + infl − pop < 2), where pop = DSC_VALID && DSC_READY.
- RD_PTR increments by 1 on each REN. The cache slot is released at issue because the data is copied into the buffer.
- infl <= REN. When infl is 1, RDATA is written into the buffer at the tail.
- DSC_DATA is the buffer head; DSC_VALID = (occ != 0). Order of descriptors is strictly preserved.
- Pop and capture in the same cycle are legal; occ is unchanged.
- FLUSH has priority over everything else. In that cycle:
  - REN = 0
  - occ <= 0
  - the returning in-flight data is dropped (infl <= 0)
  - RD_PTR <= WR_PTR
  - a pop asserted in that cycle still completes on the interface, but the data is discarded internally
- Pointer arithmetic is modulo 2^(AW+1); wrap from DEPTH−1 to 0 is natural.
- LEVEL > DEPTH is illegal; an assertion fires in simulation.
- Reset values:
  - RD_PTR = 0, occ = 0, infl = 0
  - DSC_VALID = 0, DSC_DATA = 0
  - REN forced to 0 while RESET_N is low
  - LEVEL and EMPTY follow WR_PTR
- Reset mid-operation drops the buffer and any in-flight read immediately.

## Timing
- REN is combinational from registered state, WR_PTR and DSC_READY. RADDR is registered (RD_PTR).
- WR_PTR advances in cycle N, with the buffer having space → REN in N, RDATA in N+1, DSC_VALID in N+2.
- Sustained throughput is one descriptor per cycle while the cache is non-empty and DSC_READY stays high.
- With DSC_READY held low, at most 2 descriptors are prefetched. REN stays 0 until a pop.
- DSC_DATA is stable while DSC_VALID && !DSC_READY.
- FLUSH in cycle N → DSC_VALID = 0 in N+1. The earliest new REN is in N+1.

## Configuration
- DMA_DSC_RD_ERR_EN:
  - Defined:
    - adds input DB_DETECT (1 bit, sampled alongside RDATA)
    - adds output DSC_ERR (1 bit) and output ERR_STICKY (1 bit)
    - DB_DETECT is stored per buffer entry and presented on DSC_ERR with its descriptor
    - ERR_STICKY sets on any captured error and clears on FLUSH or reset
    - the buffer entry widens by 1 bit
  - Undefined: these ports and storage are absent, and behaviour is otherwise identical.

## Structure
- Shared package dma_dsc_pkg:
  - DSC_WIDTH, DSC_DEPTH, DSC_AW constants
  - dsc_ptr_t typedef (AW+1 bits)
  - dsc_t typedef (WIDTH bits, plus the error bit under the macro)
- Sub-module dma_dsc_skid2: the two-entry FIFO with head/tail index and occupancy, with push, pop and clear inputs.
- Top level holds the pointer, infl, REN credit logic and the flush/level logic.

## Test plan
- Reset, WR_PTR=0 → REN=0, DSC_VALID=0, RD_PTR=0, EMPTY=1.
- WR_PTR 0→3 with DSC_READY=1 → REN in 3 consecutive cycles with RADDR 0,1,2. DSC_VALID from 2 cycles after the first REN, descriptors in order, RD_PTR=3.
- WR_PTR=5, DSC_READY=0 → exactly 2 REN, LEVEL=3. Raise DSC_READY → remaining 3 delivered back-to-back, no gaps.
- Wrap: RD_PTR=126, WR_PTR=130 (DEPTH 128) → RADDR 126,127,0,1, RD_PTR=130, no data loss.
- FLUSH while occ=2 and infl=1, WR_PTR=40 → next cycle DSC_VALID=0, RD_PTR=40, EMPTY=1, stale RDATA not delivered.
- With DMA_DSC_RD_ERR_EN: DB_DETECT=1 on the 2nd read → DSC_ERR=1 only with the 2nd descriptor, ERR_STICKY=1 until FLUSH.

Source files
------------

// File: rtl/dma_dsc_pkg.sv
// dma_dsc_pkg: shared constants and types for the DMA descriptor cache read path.
// DMA_DSC_RD_ERR_EN adds a per-descriptor error bit to dsc_t.
package dma_dsc_pkg;
    localparam int DSC_WIDTH = 128;
    localparam int DSC_DEPTH = 128;
    localparam int DSC_AW    = 7;
    typedef logic [DSC_AW:0] dsc_ptr_t;
`ifdef DMA_DSC_RD_ERR_EN
    typedef struct packed {
        logic                 err;
        logic [DSC_WIDTH-1:0] data;
    } dsc_t;
`else
    typedef struct packed {
        logic [DSC_WIDTH-1:0] data;
    } dsc_t;
`endif
endpackage

// File: rtl/dma_dsc_skid2.sv
// dma_dsc_skid2: two-entry FIFO absorbing the cache read latency.
// Entries reset to zero so the head reads as zero after reset.
module dma_dsc_skid2
    import dma_dsc_pkg::*;
#(
    parameter int W = DSC_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clr_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   occ_o
);
    logic [W-1:0] mem_q [2];
    logic         head_q, head_d;
    logic         tail_q, tail_d;
    logic [1:0]   occ_q, occ_d;

    always_comb begin
        head_d = clr_i ? 1'b0 : head_q ^ pop_i;
        tail_d = clr_i ? 1'b0 : tail_q ^ push_i;
        occ_d  = clr_i ? 2'd0 : occ_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i && !clr_i)
                mem_q[tail_q] <= din_i;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign dout_o = mem_q[head_q];
    assign occ_o  = occ_q;
endmodule

// File: rtl/dma_dsc_cache_rd.sv
// dma_dsc_cache_rd: circular-buffer read engine for the descriptor cache with a 2-deep output buffer.
// DMA_DSC_RD_ERR_EN adds db_detect_i, dsc_err_o and err_sticky_o.
module dma_dsc_cache_rd
    import dma_dsc_pkg::*;
#(
    parameter int WIDTH = DSC_WIDTH,
    parameter int DEPTH = DSC_DEPTH,
    parameter int AW    = DSC_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW:0]      wr_ptr_i,
    output logic [AW:0]      rd_ptr_o,
    output logic             ren_o,
    output logic [AW-1:0]    raddr_o,
    input  logic [WIDTH-1:0] rdata_i,
    output logic             dsc_valid_o,
    input  logic             dsc_ready_i,
    output logic [WIDTH-1:0] dsc_data_o,
    input  logic             flush_i,
    output logic [AW:0]      level_o,
    output logic             empty_o
`ifdef DMA_DSC_RD_ERR_EN
    ,
    input  logic             db_detect_i,
    output logic             dsc_err_o,
    output logic             err_sticky_o
`endif
);
`ifdef DMA_DSC_RD_ERR_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          infl_q;
    logic          pop, ren;
    logic [1:0]    occ;
    logic [EW-1:0] din, dout;

    assign level_o     = wr_ptr_i - rd_ptr_q;
    assign empty_o     = level_o == '0;
    assign dsc_valid_o = occ != 2'd0;
    assign pop         = dsc_valid_o && dsc_ready_i;
    // Issue only while buffer plus in-flight read leaves room after this cycle's pop.
    assign ren      = !empty_o && !flush_i && ({1'b0, occ} + {2'b0, infl_q} < 3'd2 + {2'b0, pop});
    assign ren_o    = ren && rst_n;
    assign rd_ptr_d = flush_i ? wr_ptr_i : rd_ptr_q + {{AW{1'b0}}, ren};
    assign rd_ptr_o = rd_ptr_q;
    assign raddr_o  = rd_ptr_q[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            infl_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            infl_q   <= ren;
        end
    end

`ifdef DMA_DSC_RD_ERR_EN
    logic sticky_q, sticky_d;
    assign din          = {db_detect_i, rdata_i};
    assign dsc_err_o    = dout[WIDTH];
    assign sticky_d     = flush_i ? 1'b0 : sticky_q | (infl_q & db_detect_i);
    assign err_sticky_o = sticky_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_q <= 1'b0;
        else
            sticky_q <= sticky_d;
    end
`else
    assign din = rdata_i;
`endif
    assign dsc_data_o = dout[WIDTH-1:0];

    dma_dsc_skid2 #(.W(EW)) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (infl_q && !flush_i),
        .pop_i  (pop && !flush_i),
        .clr_i  (flush_i),
        .din_i  (din),
        .dout_o (dout),
        .occ_o  (occ)
    );

    a_level_legal: assert property (@(posedge clk) disable iff (!rst_n)
        {1'b0, level_o} <= (AW+2)'(DEPTH));
endmodule
